// File: rtl/fetch_decode_alu.sv
// Instruction-path slice: 256x32 instruction memory with a registered
// read port, a combinational decoder and a combinational ALU. The PC
// controller and register bank live outside this block.
module fetch_decode_alu #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DEPTH_LOG2-1:0] pc,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [DATA_W-1:0]     prog_data,
    input  logic [DATA_W-1:0]     a_reg_data,
    input  logic [DATA_W-1:0]     b_reg_data,
    output logic [DATA_W-1:0]     inst,
    output logic [3:0]            opcode,
    output logic [2:0]            cc,
    output logic [3:0]            z_regbank_addr,
    output logic [3:0]            a_regbank_addr,
    output logic [3:0]            b_regbank_addr,
    output logic [DATA_W-1:0]     imm_data,
    output logic                  a_from_regbank,
    output logic                  b_from_regbank,
    output logic                  is_branch,
    output logic                  is_negated_branch,
    output logic                  is_call,
    output logic                  is_ret,
    output logic                  halted,
    output logic                  writes_reg,
    output logic [DATA_W-1:0]     z_data
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
        OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_SHL  = 4'h6, OP_SHR  = 4'h7,
        OP_CMP  = 4'h8, OP_MOVI = 4'h9, OP_BR   = 4'hA, OP_BRN  = 4'hB,
        OP_CALL = 4'hC, OP_RET  = 4'hD, OP_RSVD = 4'hE, OP_HALT = 4'hF
    } opcode_e;

    logic [DATA_W-1:0]        r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_W-1:0]        r_inst;
    logic                     w_bimm;
    logic signed [DATA_W-1:0] w_a_op;
    logic signed [DATA_W-1:0] w_b_op;

    // Condition evaluation for CMP; cc 6/7 are constant true/false.
    function automatic logic cmp_cond(input logic [2:0] c,
                                      input logic signed [DATA_W-1:0] a,
                                      input logic signed [DATA_W-1:0] b);
        case (c)
            3'd0:    cmp_cond = (a == b);
            3'd1:    cmp_cond = (a != b);
            3'd2:    cmp_cond = (a < b);
            3'd3:    cmp_cond = (a >= b);
            3'd4:    cmp_cond = ($unsigned(a) < $unsigned(b));
            3'd5:    cmp_cond = ($unsigned(a) >= $unsigned(b));
            3'd6:    cmp_cond = 1'b1;
            default: cmp_cond = 1'b0;
        endcase
    endfunction

    // Program-load write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (prog_we) r_mem[prog_addr] <= prog_data;
    end

    // Registered fetch (read-before-write on a same-address collision); reset forces a NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_inst <= '0;
        else        r_inst <= r_mem[pc];
    end

    assign inst           = r_inst;
    assign opcode         = r_inst[31:28];
    assign cc             = r_inst[27:25];
    assign w_bimm         = r_inst[24];
    assign z_regbank_addr = r_inst[23:20];
    assign a_regbank_addr = r_inst[19:16];
    assign b_regbank_addr = r_inst[15:12];
    assign imm_data       = {{(DATA_W-12){r_inst[11]}}, r_inst[11:0]};

    // Decoder: every flag defaults low, each opcode raises only its own.
    always_comb begin
        a_from_regbank    = 1'b0;
        b_from_regbank    = 1'b0;
        is_branch         = 1'b0;
        is_negated_branch = 1'b0;
        is_call           = 1'b0;
        is_ret            = 1'b0;
        halted            = 1'b0;
        writes_reg        = 1'b0;
        case (opcode_e'(opcode))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CMP: begin
                a_from_regbank = 1'b1;
                b_from_regbank = !w_bimm;
                writes_reg     = 1'b1;
            end
            OP_MOVI: writes_reg = 1'b1;
            OP_BR:   is_branch  = 1'b1;
            OP_BRN: begin
                is_branch         = 1'b1;
                is_negated_branch = 1'b1;
            end
            OP_CALL: begin
                is_call    = 1'b1;
                writes_reg = 1'b1;
            end
            OP_RET:  is_ret = 1'b1;
            OP_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign w_a_op = a_from_regbank ? $signed(a_reg_data) : $signed(imm_data);
    assign w_b_op = b_from_regbank ? $signed(b_reg_data) : $signed(imm_data);

    // ALU: modulo arithmetic, logical shifts by B[4:0], CMP yields a 0/1 word.
    always_comb begin
        z_data = '0;
        case (opcode_e'(opcode))
            OP_ADD:  z_data = w_a_op + w_b_op;
            OP_SUB:  z_data = w_a_op - w_b_op;
            OP_AND:  z_data = w_a_op & w_b_op;
            OP_OR:   z_data = w_a_op | w_b_op;
            OP_XOR:  z_data = w_a_op ^ w_b_op;
            OP_SHL:  z_data = $unsigned(w_a_op) << w_b_op[4:0];
            OP_SHR:  z_data = $unsigned(w_a_op) >> w_b_op[4:0];
            OP_CMP:  z_data = {{(DATA_W-1){1'b0}}, cmp_cond(cc, w_a_op, w_b_op)};
            OP_MOVI: z_data = w_b_op;
            default: z_data = '0;
        endcase
    end

endmodule

// File: tb/tb_fetch_decode_alu.sv
// Self-checking bench for fetch_decode_alu: directed scenarios plus a
// randomized sweep checked against a behavioural instruction model.
module tb_fetch_decode_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] a_reg_data;
    logic [31:0] b_reg_data;
    logic [31:0] inst;
    logic [3:0]  opcode;
    logic [2:0]  cc;
    logic [3:0]  z_regbank_addr, a_regbank_addr, b_regbank_addr;
    logic [31:0] imm_data;
    logic        a_from_regbank, b_from_regbank;
    logic        is_branch, is_negated_branch, is_call, is_ret, halted, writes_reg;
    logic [31:0] z_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mem_m [0:255];

    fetch_decode_alu #(.DATA_W(32), .DEPTH_LOG2(8)) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .a_reg_data(a_reg_data), .b_reg_data(b_reg_data),
        .inst(inst), .opcode(opcode), .cc(cc),
        .z_regbank_addr(z_regbank_addr), .a_regbank_addr(a_regbank_addr),
        .b_regbank_addr(b_regbank_addr), .imm_data(imm_data),
        .a_from_regbank(a_from_regbank), .b_from_regbank(b_from_regbank),
        .is_branch(is_branch), .is_negated_branch(is_negated_branch),
        .is_call(is_call), .is_ret(is_ret), .halted(halted),
        .writes_reg(writes_reg), .z_data(z_data)
    );

    always #5 clk = ~clk;

    // Flag vector order: {a_from, b_from, br, nbr, call, ret, halt, wr}
    function automatic logic [7:0] flags_now();
        return {a_from_regbank, b_from_regbank, is_branch, is_negated_branch,
                is_call, is_ret, halted, writes_reg};
    endfunction

    function automatic logic [31:0] sext12(input logic [31:0] w);
        int v;
        v = int'(w[11:0]);
        if (v >= 2048) v = v - 4096;
        return 32'(v);
    endfunction

    function automatic logic [7:0] model_flags(input logic [31:0] w);
        int op;
        op = int'(w[31:28]);
        if (op >= 1 && op <= 8) return {1'b1, ~w[24], 6'b000001};
        if (op == 9)  return 8'b0000_0001;
        if (op == 10) return 8'b0010_0000;
        if (op == 11) return 8'b0011_0000;
        if (op == 12) return 8'b0000_1001;
        if (op == 13) return 8'b0000_0100;
        if (op == 15) return 8'b0000_0010;
        return 8'b0;
    endfunction

    function automatic logic [31:0] model_z(input logic [31:0] w, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] imm, bv;
        longint sa, sb;
        imm = sext12(w);
        bv  = w[24] ? imm : b;
        sa  = longint'($signed(a));
        sb  = longint'($signed(bv));
        case (int'(w[31:28]))
            1: return a + bv;
            2: return a - bv;
            3: return a & bv;
            4: return a | bv;
            5: return a ^ bv;
            6: return a << bv[4:0];
            7: return a >> bv[4:0];
            8: case (int'(w[27:25]))
                   0: return (sa == sb) ? 1 : 0;
                   1: return (sa != sb) ? 1 : 0;
                   2: return (sa <  sb) ? 1 : 0;
                   3: return (sa >= sb) ? 1 : 0;
                   4: return (a <  bv) ? 1 : 0;
                   5: return (a >= bv) ? 1 : 0;
                   6: return 1;
                   default: return 0;
               endcase
            9: return imm;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] addr, input logic [31:0] word);
        prog_we = 1'b1; prog_addr = addr; prog_data = word;
        tick();
        prog_we = 1'b0;
        mem_m[addr] = word;
    endtask

    task automatic fetch(input logic [7:0] addr);
        pc = addr;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; pc = 8'd0; prog_we = 1'b0; prog_addr = 8'd0; prog_data = 32'd0;
        a_reg_data = 32'h1234_5678; b_reg_data = 32'h9abc_def0;
        #1;
        n_tests++;
        if (inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst); end
        tick(); tick();
        n_tests++;
        if (flags_now() !== 8'd0) begin n_fail++; $display("FAIL reset_flags got %b want 0", flags_now()); end
        n_tests++;
        if (z_data !== 32'd0) begin n_fail++; $display("FAIL reset_z got %h want 0", z_data); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add_sub();
        load(8'd3, 32'h1032_1000);
        fetch(8'd3);
        n_tests++;
        if (inst !== 32'h1032_1000) begin n_fail++; $display("FAIL add_inst got %h want 10321000", inst); end
        n_tests++;
        if ({writes_reg, z_regbank_addr, a_regbank_addr, b_regbank_addr} !== {1'b1, 4'd3, 4'd2, 4'd1}) begin
            n_fail++; $display("FAIL add_fields got %b %h %h %h want 1 3 2 1", writes_reg,
                               z_regbank_addr, a_regbank_addr, b_regbank_addr);
        end
        n_tests++;
        if (flags_now() !== 8'b1100_0001) begin n_fail++; $display("FAIL add_flags got %b want 11000001", flags_now()); end
        a_reg_data = 32'hFFFF_FFFF; b_reg_data = 32'd2; #1;
        n_tests++;
        if (z_data !== 32'h0000_0001) begin n_fail++; $display("FAIL add_wrap got %h want 00000001", z_data); end
        load(8'd4, 32'h2032_1000);
        fetch(8'd4);
        a_reg_data = 32'd5; b_reg_data = 32'd7; #1;
        n_tests++;
        if (z_data !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub got %h want fffffffe", z_data); end
    endtask

    task automatic test_cmp_movi();
        load(8'd10, 32'h8432_1000);
        fetch(8'd10);
        a_reg_data = 32'hFFFF_FFFF; b_reg_data = 32'd1; #1;
        n_tests++;
        if (z_data !== 32'd1) begin n_fail++; $display("FAIL cmp_lt got %h want 1", z_data); end
        load(8'd11, 32'h8832_1000);
        fetch(8'd11);
        n_tests++;
        if (z_data !== 32'd0) begin n_fail++; $display("FAIL cmp_ltu got %h want 0", z_data); end
        load(8'd12, 32'h9030_0800);
        fetch(8'd12);
        n_tests++;
        if (z_data !== 32'hFFFF_F800) begin n_fail++; $display("FAIL movi_z got %h want fffff800", z_data); end
        n_tests++;
        if (flags_now() !== 8'b0000_0001) begin n_fail++; $display("FAIL movi_flags got %b want 00000001", flags_now()); end
    endtask

    task automatic test_control();
        load(8'd20, 32'hB002_0FFC);
        fetch(8'd20);
        n_tests++;
        if (flags_now() !== 8'b0011_0000) begin n_fail++; $display("FAIL brn_flags got %b want 00110000", flags_now()); end
        n_tests++;
        if (imm_data !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL brn_imm got %h want fffffffc", imm_data); end
        load(8'd21, 32'hC0E0_0010);
        fetch(8'd21);
        n_tests++;
        if (flags_now() !== 8'b0000_1001) begin n_fail++; $display("FAIL call_flags got %b want 00001001", flags_now()); end
        load(8'd22, 32'hD00F_0000);
        fetch(8'd22);
        n_tests++;
        if (flags_now() !== 8'b0000_0100) begin n_fail++; $display("FAIL ret_flags got %b want 00000100", flags_now()); end
        load(8'd23, 32'hF000_0000);
        fetch(8'd23);
        n_tests++;
        if (flags_now() !== 8'b0000_0010) begin n_fail++; $display("FAIL halt_flags got %b want 00000010", flags_now()); end
    endtask

    task automatic test_random();
        logic [7:0]  addr;
        logic [31:0] w;
        for (int i = 0; i < 256; i++) load(8'(i), $urandom);
        for (int k = 0; k < 300; k++) begin
            addr = 8'($urandom_range(0, 255));
            fetch(addr);
            a_reg_data = $urandom; b_reg_data = $urandom;
            if (k % 8 == 0) b_reg_data = a_reg_data;
            #1;
            w = mem_m[addr];
            n_tests++;
            if (inst !== w) begin n_fail++; $display("FAIL rnd_inst @%0d got %h want %h", addr, inst, w); end
            n_tests++;
            if ({opcode, cc, z_regbank_addr, a_regbank_addr, b_regbank_addr, imm_data} !==
                {w[31:28], w[27:25], w[23:20], w[19:16], w[15:12], sext12(w)}) begin
                n_fail++; $display("FAIL rnd_fields word %h imm got %h want %h", w, imm_data, sext12(w));
            end
            n_tests++;
            if (flags_now() !== model_flags(w)) begin
                n_fail++; $display("FAIL rnd_flags word %h got %b want %b", w, flags_now(), model_flags(w));
            end
            n_tests++;
            if (z_data !== model_z(w, a_reg_data, b_reg_data)) begin
                n_fail++; $display("FAIL rnd_z word %h a %h b %h got %h want %h", w, a_reg_data,
                                   b_reg_data, z_data, model_z(w, a_reg_data, b_reg_data));
            end
        end
    endtask

    task automatic test_async_reset();
        load(8'd7, 32'hF000_0000);
        fetch(8'd7);
        n_tests++;
        if (halted !== 1'b1) begin n_fail++; $display("FAIL pre_reset_halt got %b want 1", halted); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (inst !== 32'd0) begin n_fail++; $display("FAIL async_reset_inst got %h want 0", inst); end
        n_tests++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL async_reset_halt got %b want 0", halted); end
        #1;
        reset = 1'b1;
        fetch(8'd7);
        n_tests++;
        if (inst !== 32'hF000_0000) begin n_fail++; $display("FAIL mem_kept got %h want f0000000", inst); end
    endtask

    task automatic test_back_to_back();
        load(8'd5, 32'h1111_1111);
        pc = 8'd5;
        prog_we = 1'b1; prog_addr = 8'd5; prog_data = 32'h2222_2222;
        tick();
        prog_we = 1'b0;
        n_tests++;
        if (inst !== 32'h1111_1111) begin n_fail++; $display("FAIL rw_old got %h want 11111111", inst); end
        tick();
        n_tests++;
        if (inst !== 32'h2222_2222) begin n_fail++; $display("FAIL rw_new got %h want 22222222", inst); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_cmp_movi();
        test_control();
        test_random();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
